// File: rtl/peripheral_wb2sram_bridge.sv
// Wishbone B3 registered-feedback slave that maps classic and burst cycles
// onto a single-port synchronous SRAM with one cycle of read latency.
module peripheral_wb2sram_bridge #(
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned MEM_AW = 10
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [AW-1:0]     wb_adr_i,
   input  logic [DW-1:0]     wb_dat_i,
   input  logic [DW/8-1:0]   wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic [2:0]        wb_cti_i,
   input  logic [1:0]        wb_bte_i,
   output logic [DW-1:0]     wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic [MEM_AW-1:0] sram_addr_o,
   output logic              sram_we_o,
   output logic [DW/8-1:0]   sram_be_o,
   output logic [DW-1:0]     sram_din_o,
   input  logic [DW-1:0]     sram_dout_i
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned SH = (SW > 1) ? $clog2(SW) : 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACK   = 3'd1,
      S_BURST = 3'd2,
      S_STALL = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [MEM_AW-1:0] cur;
   logic [MEM_AW-1:0] nxt;
   logic [MEM_AW-1:0] wadr;
   logic [MEM_AW-1:0] wrap_mask;
   logic              req;
   logic              burst_cti;
   logic              unused_adr;

   assign wadr       = wb_adr_i[MEM_AW+SH-1:SH];
   assign req        = wb_cyc_i & wb_stb_i;
   assign burst_cti  = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);
   // Upper and byte-lane address bits carry no meaning for the SRAM.
   assign unused_adr = ^wb_adr_i;

   // Next-beat address: linear or wrapped increment inside an aligned block.
   always_comb begin
      wrap_mask = '0;
      nxt       = cur;
      if (wb_cti_i == 3'b010) begin
         case (wb_bte_i)
            2'd1:    wrap_mask = MEM_AW'(4'h3);
            2'd2:    wrap_mask = MEM_AW'(4'h7);
            2'd3:    wrap_mask = MEM_AW'(4'hF);
            default: wrap_mask = '1;
         endcase
         nxt = (cur & ~wrap_mask) | ((cur + MEM_AW'(1)) & wrap_mask);
      end
   end

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Beat address register: loaded at cycle start, advanced on burst beats.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cur <= '0;
      end else if (state == S_IDLE && req) begin
         if (wb_cti_i == 3'b000 || wb_cti_i == 3'b111 || burst_cti) cur <= wadr;
      end else if (state == S_BURST && req && burst_cti) begin
         cur <= nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req) begin
               case (wb_cti_i)
                  3'b000, 3'b111: state_nxt = S_ACK;
                  3'b001, 3'b010: state_nxt = S_BURST;
                  default:        state_nxt = S_ERR;
               endcase
            end
         end
         S_ACK:   state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         S_BURST: begin
            if (!wb_cyc_i)      state_nxt = S_IDLE;
            else if (!wb_stb_i) state_nxt = S_STALL;
            else if (burst_cti) state_nxt = S_BURST;
            else                state_nxt = S_IDLE;
         end
         S_STALL: begin
            if (!wb_cyc_i)     state_nxt = S_IDLE;
            else if (wb_stb_i) state_nxt = S_BURST;
            else               state_nxt = S_STALL;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus and SRAM outputs; reset forces all strobes low in the same cycle.
   always_comb begin
      wb_ack_o    = 1'b0;
      wb_err_o    = 1'b0;
      sram_addr_o = '0;
      case (state)
         S_IDLE:  sram_addr_o = wadr;
         S_ACK: begin
            sram_addr_o = cur;
            wb_ack_o    = req;
         end
         S_BURST: begin
            sram_addr_o = wb_we_i ? cur : nxt;
            wb_ack_o    = req;
         end
         S_STALL: sram_addr_o = cur;
         S_ERR:   wb_err_o = req;
         default: sram_addr_o = '0;
      endcase
      if (wb_rst_i) begin
         wb_ack_o = 1'b0;
         wb_err_o = 1'b0;
      end
      sram_we_o  = wb_ack_o & wb_we_i;
      sram_be_o  = wb_sel_i;
      sram_din_o = wb_dat_i;
      wb_dat_o   = wb_ack_o ? sram_dout_i : '0;
   end

endmodule

// File: tb/tb_peripheral_wb2sram_bridge.sv
// Directed bench for the Wishbone-to-SRAM bridge with a behavioural SRAM.
module tb_peripheral_wb2sram_bridge;

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned MEM_AW = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic [AW-1:0]     adr;
   logic [DW-1:0]     dat_w;
   logic [3:0]        sel;
   logic              we, cyc, stb;
   logic [2:0]        cti;
   logic [1:0]        bte;
   logic [DW-1:0]     dat_r;
   logic              ack, err;
   logic [MEM_AW-1:0] sram_addr;
   logic              sram_we;
   logic [3:0]        sram_be;
   logic [DW-1:0]     sram_din;
   logic [DW-1:0]     sram_dout;

   logic [DW-1:0]     mem [0:(1<<MEM_AW)-1];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   peripheral_wb2sram_bridge #(.AW(AW), .DW(DW), .MEM_AW(MEM_AW)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wb_adr_i   (adr),
      .wb_dat_i   (dat_w),
      .wb_sel_i   (sel),
      .wb_we_i    (we),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_cti_i   (cti),
      .wb_bte_i   (bte),
      .wb_dat_o   (dat_r),
      .wb_ack_o   (ack),
      .wb_err_o   (err),
      .sram_addr_o(sram_addr),
      .sram_we_o  (sram_we),
      .sram_be_o  (sram_be),
      .sram_din_o (sram_din),
      .sram_dout_i(sram_dout)
   );

   // Synchronous SRAM: byte-masked write, registered read of old data.
   always @(posedge clk) begin
      if (sram_we)
         for (int b = 0; b < 4; b++)
            if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      sram_dout <= mem[sram_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
      adr = '0; dat_w = '0; sel = 4'hF;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_idle();
      cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b000; adr = 32'h10;
      step(); step();
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b exp 0", ack); end
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err); end
      checks++;
      if (sram_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b exp 0", sram_we); end
      checks++;
      if (dat_r !== 32'h0) begin failures++; $display("FAIL reset_dat got %h exp 0", dat_r); end
      step();
      rst = 1'b0;
      bus_idle();
      step();
   endtask

   task automatic test_classic_read();
      adr = 32'h10; cti = 3'b000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL cr_c0_ack got %b exp 0", ack); end
      step();
      @(negedge clk);
      checks++;
      if (ack !== 1'b1) begin failures++; $display("FAIL cr_c1_ack got %b exp 1", ack); end
      checks++;
      if (dat_r !== 32'hA5A50004) begin failures++; $display("FAIL cr_c1_dat got %h exp a5a50004", dat_r); end
      step();
      bus_idle();
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL cr_c2_ack got %b exp 0", ack); end
      checks++;
      if (dat_r !== 32'h0) begin failures++; $display("FAIL cr_c2_dat got %h exp 0", dat_r); end
      step();
   endtask

   task automatic test_classic_write();
      mem[8] = 32'h11223344;
      adr = 32'h20; sel = 4'b0011; dat_w = 32'hDEADBEEF; we = 1'b1;
      cti = 3'b000; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      checks++;
      if (sram_we !== 1'b0) begin failures++; $display("FAIL cw_c0_we got %b exp 0", sram_we); end
      step();
      @(negedge clk);
      checks++;
      if (sram_we !== 1'b1) begin failures++; $display("FAIL cw_c1_we got %b exp 1", sram_we); end
      checks++;
      if (sram_addr !== 10'h008) begin failures++; $display("FAIL cw_c1_addr got %h exp 008", sram_addr); end
      step();
      bus_idle();
      @(negedge clk);
      checks++;
      if (sram_we !== 1'b0) begin failures++; $display("FAIL cw_c2_we got %b exp 0", sram_we); end
      checks++;
      if (mem[8] !== 32'h1122BEEF) begin failures++; $display("FAIL cw_mem8 got %h exp 1122beef", mem[8]); end
      step();
   endtask

   task automatic test_wrap4_read();
      logic [31:0] exp_dat [4];
      exp_dat[0] = 32'hA5A50003; exp_dat[1] = 32'hA5A50000;
      exp_dat[2] = 32'hA5A50001; exp_dat[3] = 32'hA5A50002;
      adr = 32'h0C; cti = 3'b010; bte = 2'b01; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         cti = (i == 3) ? 3'b111 : 3'b010;
         @(negedge clk);
         checks++;
         if (ack !== 1'b1) begin failures++; $display("FAIL w4_ack beat %0d got %b exp 1", i, ack); end
         checks++;
         if (dat_r !== exp_dat[i]) begin failures++; $display("FAIL w4_dat beat %0d got %h exp %h", i, dat_r, exp_dat[i]); end
         if (i == 0) begin
            checks++;
            if (sram_addr !== 10'h000) begin failures++; $display("FAIL w4_prefetch got %h exp 000", sram_addr); end
         end
         step();
      end
      bus_idle();
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL w4_after_ack got %b exp 0", ack); end
      step();
   endtask

   task automatic test_linear_write_wrap();
      logic [MEM_AW-1:0] exp_a [3];
      exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000;
      mem[10'h3FD] = 32'h0; mem[10'h3FE] = 32'h0; mem[10'h3FF] = 32'h0;
      mem[10'h000] = 32'h0; mem[10'h001] = 32'h0;
      adr = 32'hABCD0FF8; cti = 3'b010; bte = 2'b00; we = 1'b1; sel = 4'hF;
      dat_w = 32'h0; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      checks++;
      if (sram_we !== 1'b0) begin failures++; $display("FAIL lw_c0_we got %b exp 0", sram_we); end
      step();
      for (int i = 0; i < 3; i++) begin
         cti   = (i == 2) ? 3'b111 : 3'b010;
         dat_w = 32'hB0B00000 + 32'(i);
         @(negedge clk);
         checks++;
         if (sram_we !== 1'b1 || sram_addr !== exp_a[i]) begin
            failures++;
            $display("FAIL lw_beat %0d got we=%b addr=%h exp we=1 addr=%h", i, sram_we, sram_addr, exp_a[i]);
         end
         step();
      end
      bus_idle();
      @(negedge clk);
      checks++;
      if (sram_we !== 1'b0) begin failures++; $display("FAIL lw_after_we got %b exp 0", sram_we); end
      step();
      checks++;
      if (mem[10'h3FE] !== 32'hB0B00000 || mem[10'h3FF] !== 32'hB0B00001 || mem[10'h000] !== 32'hB0B00002) begin
         failures++;
         $display("FAIL lw_mem got %h %h %h exp b0b00000 b0b00001 b0b00002", mem[10'h3FE], mem[10'h3FF], mem[10'h000]);
      end
      checks++;
      if (mem[10'h3FD] !== 32'h0 || mem[10'h001] !== 32'h0) begin
         failures++;
         $display("FAIL lw_neighbours got %h %h exp 0 0", mem[10'h3FD], mem[10'h001]);
      end
   endtask

   task automatic test_stall_read();
      adr = 32'h80; cti = 3'b010; bte = 2'b00; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (ack !== 1'b1 || dat_r !== 32'hA5A50020) begin failures++; $display("FAIL st_b0 got ack=%b dat=%h exp 1 a5a50020", ack, dat_r); end
      step();
      @(negedge clk);
      checks++;
      if (ack !== 1'b1 || dat_r !== 32'hA5A50021) begin failures++; $display("FAIL st_b1 got ack=%b dat=%h exp 1 a5a50021", ack, dat_r); end
      step();
      stb = 1'b0;
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL st_wait_ack got %b exp 0", ack); end
      step();
      stb = 1'b1;
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL st_stall_ack got %b exp 0", ack); end
      step();
      cti = 3'b111;
      @(negedge clk);
      checks++;
      if (ack !== 1'b1 || dat_r !== 32'hA5A50022) begin failures++; $display("FAIL st_b2 got ack=%b dat=%h exp 1 a5a50022", ack, dat_r); end
      step();
      bus_idle();
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL st_after_ack got %b exp 0", ack); end
      step();
   endtask

   task automatic test_err();
      adr = 32'h40; cti = 3'b100; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || sram_we !== 1'b0) begin failures++; $display("FAIL er_c0 got err=%b we=%b exp 0 0", err, sram_we); end
      step();
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || ack !== 1'b0 || sram_we !== 1'b0) begin
         failures++; $display("FAIL er_c1 got err=%b ack=%b we=%b exp 1 0 0", err, ack, sram_we);
      end
      step();
      bus_idle();
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL er_c2 got err=%b exp 0", err); end
      step();
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 4; i++) mem[10'h040 + 10'(i)] = 32'h0;
      adr = 32'h100; cti = 3'b010; bte = 2'b00; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      step();
      for (int i = 0; i < 2; i++) begin
         dat_w = 32'hC0C00000 + 32'(i);
         @(negedge clk);
         checks++;
         if (sram_we !== 1'b1) begin failures++; $display("FAIL rm_beat %0d we got %b exp 1", i, sram_we); end
         step();
      end
      dat_w = 32'hC0C00002;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || sram_we !== 1'b0) begin failures++; $display("FAIL rm_rst_cycle got ack=%b we=%b exp 0 0", ack, sram_we); end
      step();
      rst = 1'b0;
      dat_w = 32'hC0C00003;
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || sram_we !== 1'b0) begin failures++; $display("FAIL rm_next got ack=%b we=%b exp 0 0", ack, sram_we); end
      step();
      bus_idle();
      step();
      checks++;
      if (mem[10'h040] !== 32'hC0C00000 || mem[10'h041] !== 32'hC0C00001) begin
         failures++; $display("FAIL rm_written got %h %h exp c0c00000 c0c00001", mem[10'h040], mem[10'h041]);
      end
      checks++;
      if (mem[10'h042] !== 32'h0 || mem[10'h043] !== 32'h0) begin
         failures++; $display("FAIL rm_unwritten got %h %h exp 0 0", mem[10'h042], mem[10'h043]);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = {16'hA5A5, 16'(i)};
      rst = 1'b1;
      bus_idle();
      test_reset();
      test_classic_read();
      test_classic_write();
      test_wrap4_read();
      test_linear_write_wrap();
      test_stall_read();
      test_err();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
